// File: rtl/sky_display_scan.sv
// sky_display_scan: four-digit seven-segment scanner with anti-ghost blanking,
// a one-deep pending buffer on a valid/ready input, and frame-aligned
// (tear-free) updates of the displayed word.
module sky_display_scan #(
    parameter int DIGIT_CYCLES = 1000,
    parameter int BLANK_CYCLES = 50
) (
    input  logic        system1000,
    input  logic        system1000_rstn,
    input  logic        value_valid,
    input  logic [15:0] value_data,
    input  logic [3:0]  value_dp,
    output logic        value_ready,
    input  logic        lz_en,
    input  logic        led_in,
    output logic [12:0] result
);

    localparam int CW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    localparam logic PH_BLANK = 1'b0;
    localparam logic PH_SHOW  = 1'b1;
    // With no blanking configured the slot starts directly in SHOW.
    localparam logic PH_RST   = (BLANK_CYCLES > 0) ? PH_BLANK : PH_SHOW;

    localparam logic [12:0] RESULT_RST = 13'b0_1111_11111111;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          phase_q, phase_d;
    logic [15:0]   shown_q, shown_d;
    logic [3:0]    shown_dp_q, shown_dp_d;
    logic [15:0]   pend_q, pend_d;
    logic [3:0]    pend_dp_q, pend_dp_d;
    logic          pend_full_q, pend_full_d;
    logic [12:0]   result_q, result_d;

    logic wrap, frame_end, accept;
    logic [3:0] nib, an_sel;
    logic [6:0] seg7;
    logic       lead_zero;

    // Active-high gfedcba pattern for one hex digit.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    assign value_ready = !pend_full_q;
    assign result      = result_q;

    // Slot counter, digit index and BLANK/SHOW phase.
    always_comb begin
        wrap      = (cnt_q == CNT_LAST);
        frame_end = wrap && (idx_q == 2'd3);
        cnt_d     = wrap ? '0 : cnt_q + 1'b1;
        idx_d     = wrap ? idx_q + 2'd1 : idx_q;
        phase_d   = phase_q;
        if (cnt_d == BLANK_END)
            phase_d = PH_SHOW;
        else if (wrap)
            phase_d = PH_BLANK;
    end

    // Pending buffer and frame-aligned hand-over to the shown word.
    // The boundary looks at pending before this edge, so a word captured on
    // the boundary cycle itself waits for the next frame.
    always_comb begin
        accept      = value_valid && !pend_full_q;
        pend_d      = pend_q;
        pend_dp_d   = pend_dp_q;
        pend_full_d = pend_full_q;
        shown_d     = shown_q;
        shown_dp_d  = shown_dp_q;
        if (frame_end && pend_full_q) begin
            shown_d     = pend_q;
            shown_dp_d  = pend_dp_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_d      = value_data;
            pend_dp_d   = value_dp;
            pend_full_d = 1'b1;
        end
    end

    // Segment/anode encode for the current slot; registered into result.
    always_comb begin
        case (idx_q)
            2'd0: begin nib = shown_q[3:0];   lead_zero = 1'b0;                  end
            2'd1: begin nib = shown_q[7:4];   lead_zero = (shown_q[15:4] == '0);  end
            2'd2: begin nib = shown_q[11:8];  lead_zero = (shown_q[15:8] == '0);  end
            default: begin nib = shown_q[15:12]; lead_zero = (shown_q[15:12] == '0); end
        endcase
        an_sel = 4'b0001 << idx_q;
        seg7   = (lz_en && lead_zero) ? 7'h7F : ~hex7(nib);
        if (phase_q == PH_BLANK)
            result_d = {led_in, 4'b1111, 8'hFF};
        else
            result_d = {led_in, ~an_sel, ~shown_dp_q[idx_q], seg7};
    end

    // State registers.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            phase_q     <= PH_RST;
            shown_q     <= '0;
            shown_dp_q  <= '0;
            pend_q      <= '0;
            pend_dp_q   <= '0;
            pend_full_q <= 1'b0;
            result_q    <= RESULT_RST;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            phase_q     <= phase_d;
            shown_q     <= shown_d;
            shown_dp_q  <= shown_dp_d;
            pend_q      <= pend_d;
            pend_dp_q   <= pend_dp_d;
            pend_full_q <= pend_full_d;
            result_q    <= result_d;
        end
    end

endmodule

// File: tb/tb_sky_display_scan.sv
// Self-checking bench for sky_display_scan (DIGIT_CYCLES=8, BLANK_CYCLES=2).
// Reference model: time since reset release t gives slot/digit by division,
// plus a one-deep pending word that moves to the shown word at frame ends.
module tb_sky_display_scan;

    localparam int DC = 8;
    localparam int BC = 2;
    localparam int FRAME = 4 * DC;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        value_valid = 1'b0;
    logic [15:0] value_data = '0;
    logic [3:0]  value_dp = '0;
    logic        value_ready;
    logic        lz_en = 1'b0;
    logic        led_in = 1'b0;
    logic [12:0] result;

    int checks = 0;
    int errors = 0;

    // model state
    int          t = 0;
    logic [15:0] m_shown = '0;
    logic [3:0]  m_sdp = '0;
    logic        m_pfull = 1'b0;
    logic [15:0] m_pw = '0;
    logic [3:0]  m_pdp = '0;
    logic        last_acc = 1'b0;
    logic [12:0] exp_result;
    logic        exp_ready;

    logic [6:0] hex7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    sky_display_scan #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
        .system1000(clk), .system1000_rstn(rstn),
        .value_valid(value_valid), .value_data(value_data), .value_dp(value_dp),
        .value_ready(value_ready), .lz_en(lz_en), .led_in(led_in), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] model_res(int tt, logic [15:0] w, logic [3:0] d,
                                              logic lz, logic led);
        int c, i;
        logic [3:0] nib, an;
        logic [6:0] s;
        c = tt % DC;
        i = (tt / DC) % 4;
        if (c < BC) return {led, 4'hF, 8'hFF};
        nib = w[4*i +: 4];
        if (lz && i != 0 && (w >> (4*i)) == 16'd0) s = 7'h7F;
        else s = ~hex7[nib];
        an = ~(4'b0001 << i);
        return {led, an, ~d[i], s};
    endfunction

    // Advance one clock: compute expectations from pre-edge state and inputs.
    task automatic step();
        exp_result = model_res(t, m_shown, m_sdp, lz_en, led_in);
        last_acc = value_valid && !m_pfull;
        if ((t % FRAME) == FRAME - 1 && m_pfull) begin
            m_shown = m_pw; m_sdp = m_pdp; m_pfull = 1'b0;
        end
        if (last_acc) begin
            m_pfull = 1'b1; m_pw = value_data; m_pdp = value_dp;
        end
        exp_ready = !m_pfull;
        @(posedge clk); #1;
        t++;
    endtask

    task automatic model_reset();
        t = 0; m_shown = '0; m_sdp = '0; m_pfull = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (result !== 13'h0FFF || value_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold result=%h ready=%b want 0fff/1", result, value_ready);
        end
        model_reset();
        rstn = 1'b1;
        repeat (3) begin
            step();
            checks++;
            if (result !== exp_result || value_ready !== exp_ready) begin
                errors++;
                $display("FAIL reset_scan t=%0d result=%h want %h", t, result, exp_result);
            end
        end
        checks++;
        if (result !== {1'b0, 4'b1110, 8'hC0}) begin
            errors++;
            $display("FAIL reset_first_show result=%h want 0ec0", result);
        end
    endtask

    task automatic test_transfer();
        while ((t % FRAME) != 10) step();
        value_valid = 1'b1; value_data = 16'h12AF; value_dp = 4'b0100;
        step();
        value_valid = 1'b0; value_data = $urandom; value_dp = $urandom;
        repeat (2 * FRAME) begin
            step();
            checks++;
            if (result !== exp_result || value_ready !== exp_ready) begin
                errors++;
                $display("FAIL transfer t=%0d result=%h ready=%b want %h/%b",
                         t, result, value_ready, exp_result, exp_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        value_valid = 1'b1; value_data = 16'h1111; value_dp = 4'b0000;
        for (int w = 0; w < 2; w++) begin
            n = 0;
            do begin
                step();
                n++;
                checks++;
                if (result !== exp_result || value_ready !== exp_ready) begin
                    errors++;
                    $display("FAIL b2b t=%0d result=%h ready=%b want %h/%b",
                             t, result, value_ready, exp_result, exp_ready);
                end
            end while (!last_acc && n < 100);
            if (!last_acc) begin
                errors++;
                $display("FAIL b2b_accept_timeout word=%0d ready=%b want accept", w, value_ready);
            end
            value_data = 16'h2222;
        end
        value_valid = 1'b0;
        repeat (2 * FRAME) begin
            step();
            checks++;
            if (result !== exp_result || value_ready !== exp_ready) begin
                errors++;
                $display("FAIL b2b_show t=%0d result=%h want %h", t, result, exp_result);
            end
        end
        checks++;
        if (m_shown !== 16'h2222 || result[3:0] === 4'bxxxx) begin
            errors++;
            $display("FAIL b2b_final shown=%h want 2222", m_shown);
        end
    endtask

    task automatic test_boundary();
        while ((t % FRAME) != FRAME - 1 || m_pfull) step();
        value_valid = 1'b1; value_data = 16'h0005; value_dp = 4'b0000;
        step();
        value_valid = 1'b0;
        checks++;
        if (value_ready !== 1'b0) begin
            errors++;
            $display("FAIL boundary_capture ready=%b want 0", value_ready);
        end
        repeat (2 * FRAME) begin
            step();
            checks++;
            if (result !== exp_result || value_ready !== exp_ready) begin
                errors++;
                $display("FAIL boundary t=%0d result=%h ready=%b want %h/%b",
                         t, result, value_ready, exp_result, exp_ready);
            end
        end
    endtask

    task automatic test_lz();
        value_valid = 1'b1; value_data = 16'h0050; value_dp = 4'b0000;
        while (!last_acc) step();
        value_valid = 1'b0;
        while (m_pfull) step();
        for (int pass = 0; pass < 2; pass++) begin
            lz_en = (pass == 0);
            repeat (FRAME) begin
                step();
                checks++;
                if (result !== exp_result) begin
                    errors++;
                    $display("FAIL lz lz_en=%b t=%0d result=%h want %h",
                             lz_en, t, result, exp_result);
                end
            end
        end
        lz_en = 1'b0;
    endtask

    task automatic test_random();
        repeat (300) begin
            value_valid = ($urandom_range(0, 3) == 0);
            value_data = $urandom; value_dp = $urandom;
            lz_en = $urandom; led_in = $urandom;
            step();
            checks++;
            if (result !== exp_result || value_ready !== exp_ready) begin
                errors++;
                $display("FAIL random t=%0d result=%h ready=%b want %h/%b",
                         t, result, value_ready, exp_result, exp_ready);
            end
        end
        value_valid = 1'b0; lz_en = 1'b0; led_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        value_valid = 1'b1; value_data = 16'hBEEF; value_dp = 4'b1111;
        while (!(m_pfull && (t % FRAME) >= 2*DC + BC + 1 && (t % FRAME) < 3*DC) && n < 200) begin
            step();
            n++;
            if (m_pfull) value_valid = 1'b0;
        end
        value_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (result !== 13'h0FFF || value_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid result=%h ready=%b want 0fff/1", result, value_ready);
        end
        @(posedge clk); #1;
        model_reset();
        led_in = 1'b1;
        rstn = 1'b1;
        repeat (FRAME + 4) begin
            step();
            checks++;
            if (result !== exp_result || value_ready !== exp_ready) begin
                errors++;
                $display("FAIL reset_mid_after t=%0d result=%h ready=%b want %h/%b",
                         t, result, value_ready, exp_result, exp_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_transfer();
        test_back_to_back();
        test_boundary();
        test_lz();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
